seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/seq_alu_if.sv | 35 +++
 rtl/alu_core.sv | 99 +++++++++
 rtl/seq_alu.sv | 172 +++++++++++++++++
 tb/tb_seq_alu.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the sequential ALU: opcode encoding,
//               control FSM states, flag bit positions and an opcode
//               legality helper.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Opcode encoding. Values 11..15 are reserved and decode as illegal.
    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_SRA = 4'd8,
        OP_MUL = 4'd9,
        OP_ADC = 4'd10
    } op_e;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Bit positions inside the 4-bit {n, z, c, v} flags word
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= 4'd10);
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu_if
// Description : Operand/result handshake bundle for seq_alu.
//               Request side : a, b, op, in_valid -> in_ready
//               Response side: y, flags, err, out_valid <- out_ready
//               master = producer/consumer (testbench or upstream logic),
//               slave  = the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] y;
    logic [3:0]       flags;
    logic             err;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a, b, op, in_valid, out_ready,
        input  in_ready, y, flags, err, out_valid
    );

    modport slave (
        input  a, b, op, in_valid, out_ready,
        output in_ready, y, flags, err, out_valid
    );
endinterface : seq_alu_if
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Purely combinational single-cycle ALU datapath with flag
//               generation. MUL is not evaluated here (the sequencer runs it
//               iteratively); for MUL this block returns zero and err = 0.
// Ports       : i_a, i_b      operands (i_b[SHW-1:0] is the shift amount)
//               i_op          opcode
//               i_carry       stored carry, consumed by ADC
//               o_y           result
//               o_flags       {n, z, c, v}
//               o_err         illegal opcode
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    input  wire logic [3:0]       i_op,
    input  wire logic             i_carry,
    output logic      [WIDTH-1:0] o_y,
    output logic      [3:0]       o_flags,
    output logic                  o_err
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    logic [SHW-1:0] w_amt;
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;
    logic [WIDTH:0] w_adc;
    logic [WIDTH:0] w_shl;
    logic [WIDTH:0] w_shr;
    logic [WIDTH:0] w_sra;
    logic [WIDTH-1:0] w_res;
    logic w_c;
    logic w_v;
    logic w_err;

    assign w_amt  = i_b[SHW-1:0];
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    // Subtraction as a + ~b + 1 so the carry-out reads as "no borrow"
    assign w_diff = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};
    assign w_adc  = w_sum + {{WIDTH{1'b0}}, i_carry};

    // Shifts are done one bit wider so the last bit shifted out lands in the
    // guard position; with amount 0 the guard bit stays 0.
    assign w_shl  = {1'b0, i_a} << w_amt;
    assign w_shr  = {i_a, 1'b0} >> w_amt;
    assign w_sra  = $signed({i_a, 1'b0}) >>> w_amt;

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_err = 1'b0;
        case (i_op)
            OP_ADD: begin
                {w_c, w_res} = w_sum;
                w_v = (i_a[MSB] == i_b[MSB]) && (w_res[MSB] != i_a[MSB]);
            end
            OP_ADC: begin
                {w_c, w_res} = w_adc;
                w_v = (i_a[MSB] == i_b[MSB]) && (w_res[MSB] != i_a[MSB]);
            end
            OP_SUB: begin
                {w_c, w_res} = w_diff;
                w_v = (i_a[MSB] != i_b[MSB]) && (w_res[MSB] != i_a[MSB]);
            end
            OP_AND: w_res = i_a & i_b;
            OP_OR:  w_res = i_a | i_b;
            OP_XOR: w_res = i_a ^ i_b;
            OP_NOT: w_res = ~i_a;
            OP_SHL: {w_c, w_res} = w_shl;
            OP_SHR: {w_res, w_c} = w_shr;
            OP_SRA: {w_res, w_c} = w_sra;
            OP_MUL: w_res = '0;
            default: w_err = 1'b1;
        endcase
    end

    always_comb begin
        o_flags = '0;
        if (!w_err) begin
            o_flags[FLAG_N] = w_res[MSB];
            o_flags[FLAG_Z] = (w_res == '0);
            o_flags[FLAG_C] = w_c;
            o_flags[FLAG_V] = w_v;
        end
    end

    assign o_y   = w_err ? '0 : w_res;
    assign o_err = w_err;

endmodule : alu_core
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : seq_alu
// Description : Sequential ALU with valid/ready handshakes on both sides.
//               Single-cycle ops register their result one edge after
//               acceptance; MUL runs an iterative shift-add multiplier and
//               presents its result WIDTH+1 edges after acceptance.
// Ports       : clk     clock, rising edge
//               rst_n   asynchronous active-low reset
//               bus     seq_alu_if slave: a, b, op, in_valid, in_ready,
//                       y, flags, err, out_valid, out_ready
// Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    seq_alu_if.slave   bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] CNT_LAST = (SHW + 1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = (SHW + 1)'(1);

    state_e              state_q,     state_d;
    logic [WIDTH-1:0]    y_q,         y_d;
    logic [3:0]          flags_q,     flags_d;
    logic                err_q,       err_d;
    logic                out_valid_q, out_valid_d;
    logic                carry_q,     carry_d;
    logic [2*WIDTH-1:0]  acc_q,       acc_d;
    logic [2*WIDTH-1:0]  mcand_q,     mcand_d;
    logic [WIDTH-1:0]    mplier_q,    mplier_d;
    logic [SHW:0]        cnt_q,       cnt_d;

    logic [WIDTH-1:0]    w_core_y;
    logic [3:0]          w_core_flags;
    logic                w_core_err;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_consume;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_a     (bus.a),
        .i_b     (bus.b),
        .i_op    (bus.op),
        .i_carry (carry_q),
        .o_y     (w_core_y),
        .o_flags (w_core_flags),
        .o_err   (w_core_err)
    );

    // A pending result may be consumed on the same edge a new op is accepted,
    // giving one single-cycle op per clock when the consumer keeps up.
    assign w_in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_consume  = out_valid_q && bus.out_ready;

    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        flags_d     = flags_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        carry_d     = carry_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                // A single-cycle result waiting on the consumer stalls here:
                // in_ready already drops with out_ready, and staying in IDLE
                // lets the next op be taken on the very cycle it is consumed.
                if (w_accept) begin
                    if (bus.op == OP_MUL) begin
                        acc_d       = '0;
                        mcand_d     = {{WIDTH{1'b0}}, bus.a};
                        mplier_d    = bus.b;
                        cnt_d       = '0;
                        out_valid_d = 1'b0;
                        state_d     = ST_MUL;
                    end else begin
                        y_d         = w_core_y;
                        flags_d     = w_core_flags;
                        err_d       = w_core_err;
                        out_valid_d = 1'b1;
                        if (!w_core_err) begin
                            carry_d = w_core_flags[FLAG_C];
                        end
                    end
                end else if (w_consume) begin
                    out_valid_d = 1'b0;
                end
            end

            ST_MUL: begin
                if (cnt_q == CNT_LAST) begin
                    // All multiplier bits have been folded in; this cycle
                    // registers the product and its flags.
                    y_d             = acc_q[WIDTH-1:0];
                    flags_d         = '0;
                    flags_d[FLAG_N] = acc_q[WIDTH-1];
                    flags_d[FLAG_Z] = (acc_q[WIDTH-1:0] == '0);
                    flags_d[FLAG_C] = |acc_q[2*WIDTH-1:WIDTH];
                    err_d           = 1'b0;
                    carry_d         = |acc_q[2*WIDTH-1:WIDTH];
                    out_valid_d     = 1'b1;
                    state_d         = ST_HOLD;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_ONE;
                end
            end

            ST_HOLD: begin
                if (w_consume) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            y_q         <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            carry_q     <= 1'b0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            flags_q     <= flags_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            carry_q     <= carry_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.y         = y_q;
    assign bus.flags     = flags_q;
    assign bus.err       = err_q;
    assign bus.out_valid = out_valid_q;

endmodule : seq_alu
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_alu
// Description : Directed self-checking testbench for seq_alu (WIDTH = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;
    import alu_pkg::*;

    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    seq_alu_if #(.WIDTH(WIDTH)) bus ();

    seq_alu #(
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Present an operation just after the falling edge
    task automatic present(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        #1;
    endtask

    // Let the rising edge take the operation, then withdraw it
    task automatic take_edge();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.y !== 8'h00) begin n_mis++; $display("FAIL reset_y: got %h expected 00", bus.y); end
        n_cmp++; if (bus.flags !== 4'h0) begin n_mis++; $display("FAIL reset_flags: got %b expected 0000", bus.flags); end
        n_cmp++; if (bus.err !== 1'b0) begin n_mis++; $display("FAIL reset_err: got %b expected 0", bus.err); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_mis++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_add_adc();
        present(OP_ADD, 8'hFF, 8'h01);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_mis++; $display("FAIL add_in_ready: got %b expected 1", bus.in_ready); end
        take_edge();
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_mis++; $display("FAIL add_latency: out_valid got %b expected 1", bus.out_valid); end
        n_cmp++; if (bus.y !== 8'h00) begin n_mis++; $display("FAIL add_y: got %h expected 00", bus.y); end
        n_cmp++; if (bus.flags !== 4'b0110) begin n_mis++; $display("FAIL add_flags: got %b expected 0110", bus.flags); end
        present(OP_ADC, 8'h00, 8'h00);
        take_edge();
        n_cmp++; if (bus.y !== 8'h01) begin n_mis++; $display("FAIL adc_y: got %h expected 01", bus.y); end
        n_cmp++; if (bus.flags !== 4'b0000) begin n_mis++; $display("FAIL adc_flags: got %b expected 0000", bus.flags); end
    endtask

    task automatic test_sub();
        present(OP_SUB, 8'h80, 8'h01);
        take_edge();
        n_cmp++; if (bus.y !== 8'h7F) begin n_mis++; $display("FAIL sub1_y: got %h expected 7f", bus.y); end
        n_cmp++; if (bus.flags !== 4'b0011) begin n_mis++; $display("FAIL sub1_flags: got %b expected 0011", bus.flags); end
        present(OP_SUB, 8'h03, 8'h05);
        take_edge();
        n_cmp++; if (bus.y !== 8'hFE) begin n_mis++; $display("FAIL sub2_y: got %h expected fe", bus.y); end
        n_cmp++; if (bus.flags !== 4'b1000) begin n_mis++; $display("FAIL sub2_flags: got %b expected 1000", bus.flags); end
    endtask

    task automatic test_shift();
        present(OP_SHL, 8'h81, 8'h01);
        take_edge();
        n_cmp++; if (bus.y !== 8'h02) begin n_mis++; $display("FAIL shl_y: got %h expected 02", bus.y); end
        n_cmp++; if (bus.flags !== 4'b0010) begin n_mis++; $display("FAIL shl_flags: got %b expected 0010", bus.flags); end
        present(OP_SRA, 8'h80, 8'h03);
        take_edge();
        n_cmp++; if (bus.y !== 8'hF0) begin n_mis++; $display("FAIL sra_y: got %h expected f0", bus.y); end
        n_cmp++; if (bus.flags !== 4'b1000) begin n_mis++; $display("FAIL sra_flags: got %b expected 1000", bus.flags); end
        // b = 0x08: only b[2:0] counts, so the amount is 0
        present(OP_SHR, 8'hA5, 8'h08);
        take_edge();
        n_cmp++; if (bus.y !== 8'hA5) begin n_mis++; $display("FAIL shr0_y: got %h expected a5", bus.y); end
        n_cmp++; if (bus.flags !== 4'b1000) begin n_mis++; $display("FAIL shr0_flags: got %b expected 1000", bus.flags); end
    endtask

    task automatic test_mul();
        int  lat;
        bit  ready_seen;
        lat = 0;
        ready_seen = 1'b0;
        present(OP_MUL, 8'h10, 8'h11);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_mis++; $display("FAIL mul_accept: in_ready got %b expected 1", bus.in_ready); end
        @(posedge clk);
        #1;
        // Keep a conflicting request on the bus; it must be ignored in MUL
        bus.op = OP_ADD;
        bus.a  = 8'h00;
        bus.b  = 8'h00;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            if (bus.in_ready !== 1'b0) ready_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (lat != 9) begin n_mis++; $display("FAIL mul_latency: got %0d cycles expected 9", lat); end
        n_cmp++; if (ready_seen !== 1'b0) begin n_mis++; $display("FAIL mul_in_ready: in_ready seen %b expected 0", ready_seen); end
        n_cmp++; if (bus.y !== 8'h10) begin n_mis++; $display("FAIL mul_y: got %h expected 10", bus.y); end
        n_cmp++; if (bus.flags !== 4'b0010) begin n_mis++; $display("FAIL mul_flags: got %b expected 0010", bus.flags); end
        @(posedge clk);
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_mis++; $display("FAIL mul_consumed: out_valid got %b expected 0", bus.out_valid); end
        // The MUL carry-out (1) feeds the following ADC
        present(OP_ADC, 8'h00, 8'h00);
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_mis++; $display("FAIL mul_idle: in_ready got %b expected 1", bus.in_ready); end
        take_edge();
        n_cmp++; if (bus.y !== 8'h01) begin n_mis++; $display("FAIL mul_carry_adc: got %h expected 01", bus.y); end
    endtask

    task automatic test_back_to_back();
        present(OP_ADD, 8'h12, 8'h34);
        take_edge();
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.y !== 8'h46) begin n_mis++; $display("FAIL bp_y: got %h expected 46", bus.y); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.op       = OP_SUB;
            bus.a        = 8'h01;
            bus.b        = 8'h01;
            bus.in_valid = 1'b1;
            #1;
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_mis++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
            @(posedge clk);
            #1;
            n_cmp++; if (bus.y !== 8'h46 || bus.flags !== 4'b0000 || bus.out_valid !== 1'b1)
                begin n_mis++; $display("FAIL bp_hold[%0d]: got y=%h flags=%b ov=%b expected 46 0000 1", i, bus.y, bus.flags, bus.out_valid); end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.op        = OP_XOR;
        bus.a         = 8'h0F;
        bus.b         = 8'hFF;
        bus.in_valid  = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_mis++; $display("FAIL bp_release: in_ready got %b expected 1", bus.in_ready); end
        take_edge();
        n_cmp++; if (bus.y !== 8'hF0) begin n_mis++; $display("FAIL b2b_y: got %h expected f0", bus.y); end
        n_cmp++; if (bus.flags !== 4'b1000) begin n_mis++; $display("FAIL b2b_flags: got %b expected 1000", bus.flags); end
        @(posedge clk);
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_mis++; $display("FAIL b2b_drop: out_valid got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_illegal();
        present(OP_ADD, 8'hFF, 8'h01);
        take_edge();
        present(4'hC, 8'h05, 8'h06);
        take_edge();
        n_cmp++; if (bus.y !== 8'h00) begin n_mis++; $display("FAIL illegal_y: got %h expected 00", bus.y); end
        n_cmp++; if (bus.flags !== 4'b0000) begin n_mis++; $display("FAIL illegal_flags: got %b expected 0000", bus.flags); end
        n_cmp++; if (bus.err !== 1'b1) begin n_mis++; $display("FAIL illegal_err: got %b expected 1", bus.err); end
        // Carry from the ADD survives the illegal op
        present(OP_ADC, 8'h00, 8'h00);
        take_edge();
        n_cmp++; if (bus.y !== 8'h01) begin n_mis++; $display("FAIL illegal_carry: got %h expected 01", bus.y); end
        n_cmp++; if (bus.err !== 1'b0) begin n_mis++; $display("FAIL legal_err: got %b expected 0", bus.err); end
    endtask

    task automatic test_reset_mid_mul();
        bit seen;
        seen = 1'b0;
        present(OP_MUL, 8'hFF, 8'hFF);
        take_edge();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.y !== 8'h00 || bus.flags !== 4'h0 || bus.err !== 1'b0 || bus.out_valid !== 1'b0)
            begin n_mis++; $display("FAIL mulrst_outputs: got y=%h flags=%b err=%b ov=%b expected all 0", bus.y, bus.flags, bus.err, bus.out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_mis++; $display("FAIL mulrst_in_ready: got %b expected 1", bus.in_ready); end
        repeat (15) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_mis++; $display("FAIL mulrst_no_result: out_valid seen %b expected 0", seen); end
    endtask

    initial begin
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_add_adc();
        test_sub();
        test_shift();
        test_mul();
        test_back_to_back();
        test_illegal();
        test_reset_mid_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_seq_alu
`default_nettype wire
